// File: rtl/csa_resolve_serial_if.sv
// Carry-save pair in, resolved binary word out; master = upstream multiplier side.
interface csa_resolve_serial_if #(
    parameter int unsigned W = 3128
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         out_valid;

    modport master (
        output in_valid, r0, r1,
        input  in_ready, sum, carry_out, out_valid
    );

    modport slave (
        input  in_valid, r0, r1,
        output in_ready, sum, carry_out, out_valid
    );
endinterface

// File: rtl/csa_resolve_serial.sv
// Resolves a latched carry-save pair (r0, r1) into r0+r1 using one CHUNK-bit
// adder swept over NCH cycles, lowest chunk first.
module csa_resolve_serial #(
    parameter int unsigned SIZE  = 3072,
    parameter int unsigned RADIX = 54,
    parameter int unsigned CHUNK = 136
) (
    input  logic                 clk,
    input  logic                 rst,
    csa_resolve_serial_if.slave  bus
);
    localparam int unsigned W     = SIZE + RADIX + 2;
    localparam int unsigned NCH   = W / CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH + 1) : 1;
    localparam int unsigned OFF_W = $clog2(W + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

    if ((W % CHUNK) != 0) begin : g_chunk_check
        $error("csa_resolve_serial: data width must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [W-1:0]       a_q, b_q;
    logic [W-1:0]       sum_q;
    logic               carry_out_q;
    logic               out_valid_q;
    logic               in_ready_c;
    logic               accept_c;
    logic [OFF_W-1:0]   base_c;
    logic [CHUNK:0]     chunk_sum_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake
    always_comb begin
        state_d    = state_q;
        in_ready_c = (state_q == IDLE) || (state_q == DONE);
        accept_c   = bus.in_valid & in_ready_c;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = accept_c ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One chunk of the ripple: current slice of both operands plus the running carry
    always_comb begin
        base_c      = OFF_W'(idx_q) * OFF_W'(CHUNK);
        chunk_sum_c = {1'b0, a_q[base_c +: CHUNK]} + {1'b0, b_q[base_c +: CHUNK]}
                    + (CHUNK+1)'(carry_q);
    end

    // Operand latches and result datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept_c) begin
                a_q     <= bus.r0;
                b_q     <= bus.r1;
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state_q == RUN) begin
                sum_q[base_c +: CHUNK] <= chunk_sum_c[CHUNK-1:0];
                carry_q                <= chunk_sum_c[CHUNK];
                idx_q                  <= idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    carry_out_q <= chunk_sum_c[CHUNK];
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_csa_resolve_serial.sv
// Directed bench for csa_resolve_serial: latency, ripple, back-to-back, reset abort.
module tb_csa_resolve_serial;
    localparam int unsigned W   = 3128;
    localparam int unsigned NCH = 23;

    logic clk = 1'b0;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;
    int   pulses = 0;
    int   exp_pulses = 0;

    csa_resolve_serial_if #(.W(W)) bus ();

    csa_resolve_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.out_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed(low64)=%h expected(low64)=%h", tag, obs[63:0], exp_v[63:0]);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W+31:0] t;
        t = '0;
        for (int i = 0; i < int'(W); i += 32) t[i +: 32] = $urandom();
        return t[W-1:0];
    endfunction

    // Present one pair, scramble inputs after accept, then check latency and result
    task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_s, input logic exp_co);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.r0 = a; bus.r1 = b;
        chk({tag, ".rdy"}, (W+1)'(bus.in_ready), (W+1)'(1'b1));
        @(negedge clk);
        bus.in_valid = 1'b0; bus.r0 = ~a; bus.r1 = ~b;
        exp_pulses++;
        chk({tag, ".busy"}, (W+1)'(bus.in_ready), (W+1)'(1'b0));
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        chk({tag, ".lat"}, (W+1)'(lat), (W+1)'(NCH + 1));
        chk({tag, ".sum"}, (W+1)'(bus.sum), (W+1)'(exp_s));
        chk({tag, ".co"},  (W+1)'(bus.carry_out), (W+1)'(exp_co));
        @(negedge clk);
        chk({tag, ".pulse1"}, (W+1)'(bus.out_valid), (W+1)'(1'b0));
    endtask

    initial begin
        logic [W-1:0] x, ones, a, b;
        logic [W:0]   m;
        int           lat, pre;

        ones = '1;
        rst = 1'b1; bus.in_valid = 1'b0; bus.r0 = '0; bus.r1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst.rdy", (W+1)'(bus.in_ready),  (W+1)'(1'b1));
        chk("rst.ov",  (W+1)'(bus.out_valid), (W+1)'(1'b0));
        chk("rst.sum", (W+1)'(bus.sum),       '0);
        chk("rst.co",  (W+1)'(bus.carry_out), '0);

        // Full-length ripple through every chunk
        run_pair("ripple", W'(1), ones, '0, 1'b1);
        run_pair("small", W'(64'h1234_5678), W'(64'hFFFF_0000), W'(64'h1_1233_5678), 1'b0);
        run_pair("maxmax", ones, ones, ~W'(1), 1'b1);
        x = '0; x[136] = 1'b1;
        run_pair("chunk0", x - W'(1), W'(1), x, 1'b0);

        // Back-to-back: second pair held through RUN, taken on the DONE edge
        x = '0; x[200] = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.r0 = W'(5); bus.r1 = W'(7);
        @(negedge clk);
        bus.r0 = x - W'(1); bus.r1 = W'(1);
        exp_pulses++;
        repeat (5) @(negedge clk);
        chk("b2b.busy", (W+1)'(bus.in_ready), (W+1)'(1'b0));
        lat = 6;
        while (bus.out_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        chk("b2b.lat1", (W+1)'(lat), (W+1)'(NCH + 1));
        chk("b2b.sum1", (W+1)'(bus.sum), (W+1)'(12));
        chk("b2b.rdy",  (W+1)'(bus.in_ready), (W+1)'(1'b1));
        @(negedge clk);
        bus.in_valid = 1'b0; bus.r0 = '0; bus.r1 = '0;
        exp_pulses++;
        chk("b2b.gap", (W+1)'(bus.out_valid), (W+1)'(1'b0));
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        chk("b2b.lat2", (W+1)'(lat), (W+1)'(NCH + 1));
        chk("b2b.sum2", (W+1)'(bus.sum), (W+1)'(x));
        chk("b2b.co2",  (W+1)'(bus.carry_out), (W+1)'(1'b0));
        @(negedge clk);

        // Reset in the middle of a carry-heavy run
        @(negedge clk);
        bus.in_valid = 1'b1; bus.r0 = ones; bus.r1 = ones;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.ov",  (W+1)'(bus.out_valid), (W+1)'(1'b0));
        chk("abort.sum", (W+1)'(bus.sum),       '0);
        chk("abort.co",  (W+1)'(bus.carry_out), '0);
        rst = 1'b0;
        pre = pulses;
        repeat (40) @(negedge clk);
        chk("abort.nopulse", (W+1)'(pulses), (W+1)'(pre));
        chk("abort.rdy", (W+1)'(bus.in_ready), (W+1)'(1'b1));
        run_pair("postrst", W'(3), W'(4), W'(7), 1'b0);

        // A few random full-width pairs against an unsigned W+1 bit model
        for (int k = 0; k < 8; k++) begin
            a = rnd_word();
            b = rnd_word();
            m = {1'b0, a} + {1'b0, b};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_pair($sformatf("rnd%0d", k), a, b, m[W-1:0], m[W]);
        end

        repeat (3) @(negedge clk);
        chk("pulse.count", (W+1)'(pulses), (W+1)'(exp_pulses));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
